fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of decode.
- Owns the PC register, the instruction-memory request/response handshake and the IF/ID pipeline register.
- Consumes stall, flush and redirect controls from the hazard unit and execute stage; produces InstrD/PCD/PCPlus4D for decode.
- Tolerates multi-cycle instruction memory: wait states insert bubbles, and a redirect during an outstanding fetch kills that fetch.

---
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory handshake and IF/ID register.
// Tolerates multi-cycle memory; a redirect during an outstanding fetch orphans it (KILL).
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        StallF_i,
    input  logic        StallD_i,
    input  logic        FlushD_i,
    input  logic        PCSrcE_i,
    input  logic [31:0] PCTargetE_i,
    output logic        ImemReq_o,
    output logic [31:0] ImemAddr_o,
    input  logic        ImemReady_i,
    input  logic [31:0] ImemRdata_i,
    output logic [31:0] InstrD_o,
    output logic [31:0] PCD_o,
    output logic [31:0] PCPlus4D_o,
    output logic        ValidD_o
);

    typedef enum logic [1:0] {BOOT, FETCH, KILL} state_t;

    state_t      r_state, w_stateNext;
    logic [31:0] r_pcF, w_pcFNext;
    logic [31:0] r_reqAddr, w_reqAddrNext;
    logic        r_pending, w_pendingNext;
    logic        r_holdValid, w_holdValidNext;
    logic [31:0] r_holdInstr, w_holdInstrNext;
    logic [31:0] r_holdPC, w_holdPCNext;
    logic [31:0] r_instrD, w_instrDNext;
    logic [31:0] r_pcD, w_pcDNext;
    logic [31:0] r_pcPlus4D, w_pcPlus4DNext;
    logic        r_validD, w_validDNext;

    logic        w_req;
    logic        w_acc;
    logic [31:0] w_addr;
    logic [31:0] w_addrPlus4;
    logic [31:0] w_holdPCPlus4;

    // An outstanding request (pending or orphaned) keeps its address until accepted.
    assign w_req         = (r_state == KILL) || r_pending ||
                           ((r_state == FETCH) && !r_holdValid && !StallF_i);
    assign w_addr        = (r_pending || (r_state == KILL)) ? r_reqAddr : r_pcF;
    assign w_acc         = w_req && ImemReady_i;
    assign w_addrPlus4   = w_addr + 32'd4;
    assign w_holdPCPlus4 = r_holdPC + 32'd4;

    assign ImemReq_o  = w_req;
    assign ImemAddr_o = w_addr;
    assign InstrD_o   = r_instrD;
    assign PCD_o      = r_pcD;
    assign PCPlus4D_o = r_pcPlus4D;
    assign ValidD_o   = r_validD;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= BOOT;
            r_pcF       <= RESET_PC;
            r_reqAddr   <= RESET_PC;
            r_pending   <= 1'b0;
            r_holdValid <= 1'b0;
            r_holdInstr <= NOP_INSTR;
            r_holdPC    <= 32'd0;
            r_instrD    <= NOP_INSTR;
            r_pcD       <= 32'd0;
            r_pcPlus4D  <= 32'd0;
            r_validD    <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pcF       <= w_pcFNext;
            r_reqAddr   <= w_reqAddrNext;
            r_pending   <= w_pendingNext;
            r_holdValid <= w_holdValidNext;
            r_holdInstr <= w_holdInstrNext;
            r_holdPC    <= w_holdPCNext;
            r_instrD    <= w_instrDNext;
            r_pcD       <= w_pcDNext;
            r_pcPlus4D  <= w_pcPlus4DNext;
            r_validD    <= w_validDNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_pcFNext       = r_pcF;
        w_reqAddrNext   = w_req ? w_addr : r_reqAddr;
        w_pendingNext   = w_req && !ImemReady_i;
        w_holdValidNext = r_holdValid;
        w_holdInstrNext = r_holdInstr;
        w_holdPCNext    = r_holdPC;
        w_instrDNext    = r_instrD;
        w_pcDNext       = r_pcD;
        w_pcPlus4DNext  = r_pcPlus4D;
        w_validDNext    = r_validD;

        if (PCSrcE_i) begin
            // Redirect discards accepted data and any held instruction.
            w_pcFNext       = PCTargetE_i;
            w_holdValidNext = 1'b0;
            w_stateNext     = (w_req && !ImemReady_i) ? KILL : FETCH;
            if (FlushD_i || !StallD_i) begin
                w_instrDNext   = NOP_INSTR;
                w_pcDNext      = 32'd0;
                w_pcPlus4DNext = 32'd0;
                w_validDNext   = 1'b0;
            end
        end else if (r_state == KILL) begin
            if (w_acc) begin
                w_stateNext = FETCH;
            end
            if (FlushD_i || !StallD_i) begin
                w_instrDNext   = NOP_INSTR;
                w_pcDNext      = 32'd0;
                w_pcPlus4DNext = 32'd0;
                w_validDNext   = 1'b0;
            end
        end else begin
            w_stateNext = FETCH;
            if (r_holdValid && !StallD_i && !FlushD_i) begin
                w_instrDNext    = r_holdInstr;
                w_pcDNext       = r_holdPC;
                w_pcPlus4DNext  = w_holdPCPlus4;
                w_validDNext    = 1'b1;
                w_holdValidNext = 1'b0;
            end else if (w_acc) begin
                w_pcFNext = w_addrPlus4;
                if (StallD_i) begin
                    w_holdInstrNext = ImemRdata_i;
                    w_holdPCNext    = w_addr;
                    w_holdValidNext = 1'b1;
                    if (FlushD_i) begin
                        w_instrDNext   = NOP_INSTR;
                        w_pcDNext      = 32'd0;
                        w_pcPlus4DNext = 32'd0;
                        w_validDNext   = 1'b0;
                    end
                end else if (FlushD_i) begin
                    w_instrDNext   = NOP_INSTR;
                    w_pcDNext      = 32'd0;
                    w_pcPlus4DNext = 32'd0;
                    w_validDNext   = 1'b0;
                end else begin
                    w_instrDNext   = ImemRdata_i;
                    w_pcDNext      = w_addr;
                    w_pcPlus4DNext = w_addrPlus4;
                    w_validDNext   = 1'b1;
                end
            end else if (FlushD_i || !StallD_i) begin
                w_instrDNext   = NOP_INSTR;
                w_pcDNext      = 32'd0;
                w_pcPlus4DNext = 32'd0;
                w_validDNext   = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for the multi-cycle
// corner cases, then randomized traffic against a queue-based reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stallF, stallD, flushD, pcSrc, ready;
    logic [31:0] target;
    logic        imemReq;
    logic [31:0] imemAddr, imemRdata, instrD, pcD, pcPlus4D;
    logic        validD;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from its address so every fetch is traceable.
    assign imemRdata = imemAddr ^ 32'h0000_00A5;

    fetch_stage dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .StallF_i    (stallF),
        .StallD_i    (stallD),
        .FlushD_i    (flushD),
        .PCSrcE_i    (pcSrc),
        .PCTargetE_i (target),
        .ImemReq_o   (imemReq),
        .ImemAddr_o  (imemAddr),
        .ImemReady_i (ready),
        .ImemRdata_i (imemRdata),
        .InstrD_o    (instrD),
        .PCD_o       (pcD),
        .PCPlus4D_o  (pcPlus4D),
        .ValidD_o    (validD)
    );

    typedef struct {
        logic        sF;
        logic        sD;
        logic        rdy;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePC;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } hold_t;

    // Reference model state
    logic        mBoot, mOut, mOrphan;
    logic [31:0] mPC, mOutAddr;
    hold_t       holdQ[$];
    logic        mValid;
    logic [31:0] mInstr, mPCD, mPCP4;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic sF, input logic sD, input logic fD, input logic pS,
                                 input logic [31:0] tgt, input logic rdy);
        stallF = sF;
        stallD = sD;
        flushD = fD;
        pcSrc  = pS;
        target = tgt;
        ready  = rdy;
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic eValid, input logic [31:0] ePC);
        checkOutput({tag, " validD"}, {31'd0, validD}, {31'd0, eValid});
        checkOutput({tag, " instrD"}, instrD, eValid ? (ePC ^ 32'h0000_00A5) : NOP);
        checkOutput({tag, " pcD"}, pcD, eValid ? ePC : 32'd0);
        checkOutput({tag, " pcPlus4D"}, pcPlus4D, eValid ? ePC + 32'd4 : 32'd0);
    endtask

    // One clock: drive at the negedge, check request, then check IF/ID after the edge.
    task automatic cyc(input string tag, input logic sF, input logic sD, input logic fD,
                       input logic pS, input logic [31:0] tgt, input logic rdy,
                       input logic eReq, input logic [31:0] eAddr,
                       input logic eValid, input logic [31:0] ePC);
        applyStimulus(sF, sD, fD, pS, tgt, rdy);
        checkOutput({tag, " req"}, {31'd0, imemReq}, {31'd0, eReq});
        if (eReq) checkOutput({tag, " addr"}, imemAddr, eAddr);
        @(posedge clk);
        #1;
        checkRegs(tag, eValid, ePC);
        @(negedge clk);
    endtask

    task automatic resetDut();
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("reset req", {31'd0, imemReq}, 32'd0);
        checkRegs("reset", 1'b0, 32'd0);
        rstN = 1'b1;
    endtask

    task automatic mBubble();
        mValid = 1'b0;
        mInstr = NOP;
        mPCD   = 32'd0;
        mPCP4  = 32'd0;
    endtask

    task automatic mLoad(input logic [31:0] instr, input logic [31:0] pc);
        mValid = 1'b1;
        mInstr = instr;
        mPCD   = pc;
        mPCP4  = pc + 32'd4;
    endtask

    task automatic randomPhase(input int cycles);
        logic        sF, sD, fD, pS, rdy, mReq, acc, stuck;
        logic [31:0] tgt, mAddr, data;
        hold_t       h;
        mBoot = 1'b1; mOut = 1'b0; mOrphan = 1'b0; mPC = 32'd0; mOutAddr = 32'd0;
        holdQ.delete();
        mBubble();
        for (int n = 0; n < cycles; n++) begin
            sF  = ($urandom % 4) == 0;
            sD  = ($urandom % 4) == 0;
            pS  = ($urandom % 8) == 0;
            fD  = pS && ($urandom % 2 == 0);
            rdy = ($urandom % 3) != 0;
            tgt = ($urandom % 10 == 0) ? 32'hFFFF_FFF8 + 32'(($urandom % 2) * 4)
                                       : {24'd0, 6'($urandom_range(0, 63)), 2'b00};

            mReq  = !mBoot && (mOut || (holdQ.size() == 0 && !sF));
            mAddr = mOut ? mOutAddr : mPC;
            acc   = mReq && rdy;
            stuck = mReq && !rdy;
            data  = mAddr ^ 32'h0000_00A5;

            applyStimulus(sF, sD, fD, pS, tgt, rdy);
            checkOutput("rand req", {31'd0, imemReq}, {31'd0, mReq});
            if (mReq) checkOutput("rand addr", imemAddr, mAddr);

            if (pS) begin
                mPC = tgt;
                holdQ.delete();
                mOrphan = stuck;
                if (fD || !sD) mBubble();
            end else if (mOrphan) begin
                if (acc) mOrphan = 1'b0;
                if (fD || !sD) mBubble();
            end else if (holdQ.size() > 0 && !sD && !fD) begin
                h = holdQ.pop_front();
                mLoad(h.instr, h.pc);
            end else if (acc) begin
                mPC = mAddr + 32'd4;
                if (sD) begin
                    holdQ.push_back('{data, mAddr});
                    if (fD) mBubble();
                end else if (fD) begin
                    mBubble();
                end else begin
                    mLoad(data, mAddr);
                end
            end else if (fD || !sD) begin
                mBubble();
            end
            mOut = stuck;
            if (stuck) mOutAddr = mAddr;
            mBoot = 1'b0;

            @(posedge clk);
            #1;
            checkOutput("rand validD", {31'd0, validD}, {31'd0, mValid});
            checkOutput("rand instrD", instrD, mInstr);
            checkOutput("rand pcD", pcD, mPCD);
            checkOutput("rand pcPlus4D", pcPlus4D, mPCP4);
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};  // BOOT cycle
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h4};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h8};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hC, 1'b1, 32'hC};

        @(negedge clk);
        resetDut();
        for (int i = 0; i < 7; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].sF, vecs[i].sD, 1'b0, 1'b0, 32'd0, vecs[i].rdy,
                vecs[i].eReq, vecs[i].eAddr, vecs[i].eValid, vecs[i].ePC);
        end

        // Redirect while 0x10 is pending: the orphaned fetch never decodes.
        cyc("kill0", 0, 0, 0, 1, 32'h100, 0, 1, 32'h10, 0, 32'h0);
        cyc("kill1", 0, 0, 0, 0, 32'h0, 0, 1, 32'h10, 0, 32'h0);
        cyc("kill2", 0, 0, 0, 0, 32'h0, 1, 1, 32'h10, 0, 32'h0);
        cyc("kill3", 0, 0, 0, 0, 32'h0, 1, 1, 32'h100, 1, 32'h100);

        // Accept 0x14 into the hold buffer while decode stalls.
        cyc("hold0", 0, 0, 0, 1, 32'h10, 1, 1, 32'h104, 0, 32'h0);
        cyc("hold1", 0, 0, 0, 0, 32'h0, 1, 1, 32'h10, 1, 32'h10);
        cyc("hold2", 0, 1, 0, 0, 32'h0, 1, 1, 32'h14, 1, 32'h10);
        for (int i = 0; i < 3; i++) cyc("holdStall", 1, 1, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h10);
        cyc("holdDrain", 0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h14);
        cyc("holdNext", 0, 0, 0, 0, 32'h0, 1, 1, 32'h18, 1, 32'h18);

        // Held instruction discarded by a flushing redirect.
        cyc("flush0", 0, 1, 0, 0, 32'h0, 1, 1, 32'h1C, 1, 32'h18);
        cyc("flush1", 0, 1, 1, 1, 32'h40, 1, 0, 32'h0, 0, 32'h0);
        cyc("flush2", 0, 0, 0, 0, 32'h0, 1, 1, 32'h40, 1, 32'h40);

        // PC wraps past the top of the address space.
        cyc("wrap0", 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h44, 0, 32'h0);
        cyc("wrap1", 0, 0, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        cyc("wrap2", 0, 0, 0, 0, 32'h0, 1, 1, 32'h0, 1, 32'h0);

        // Asynchronous reset in the middle of a wait state at 0x20.
        cyc("rstWait0", 0, 0, 0, 1, 32'h20, 1, 1, 32'h4, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("rstWait req before", {31'd0, imemReq}, 32'd1);
        checkOutput("rstWait addr before", imemAddr, 32'h20);
        rstN = 1'b0;
        #1;
        checkOutput("rstWait req dropped", {31'd0, imemReq}, 32'd0);
        checkRegs("rstWait", 1'b0, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        cyc("rstBoot", 0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
        cyc("rstFirst", 0, 0, 0, 0, 32'h0, 1, 1, 32'h0, 1, 32'h0);

        resetDut();
        randomPhase(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
